// File: rtl/j4_stack.sv
// j4 data/return stack: T held in a register, deeper items in a circular array.
// Supports deltas 0/+1/-1/-2, wrap or saturate on faults, ovf/unf pulses and a sticky err.
module j4_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       delta,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] n,
    output logic [DEPTH:0]   dsp,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic             err
);
    localparam int CAP = 1 << DEPTH;
    localparam logic [DEPTH:0] CAP_V = (DEPTH+1)'(CAP);
    localparam logic [DEPTH:0] ONE   = (DEPTH+1)'(1);
    localparam logic [DEPTH:0] TWO   = (DEPTH+1)'(2);
    localparam logic [DEPTH:0] THREE = (DEPTH+1)'(3);

    // item[k] for k>=1 lives at mem[sp_reg-(k-1)]; one slot is always spare
    logic [WIDTH-1:0] mem [CAP];

    logic [WIDTH-1:0] t_reg, t_next;
    logic [DEPTH-1:0] sp_reg, sp_next;
    logic [DEPTH:0]   dsp_reg, dsp_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             err_reg, err_next;

    logic [DEPTH-1:0] sp_inc, sp_dec, sp_dec2;
    logic [WIDTH-1:0] item0, item1, item2;
    logic [WIDTH-1:0] dflt, val;
    logic             push, pop1, pop2, over, under, suppress, mem_we;

    assign sp_inc  = sp_reg + DEPTH'(1);
    assign sp_dec  = sp_reg - DEPTH'(1);
    assign sp_dec2 = sp_reg - DEPTH'(2);

    // Items beyond dsp read as zero everywhere, including as shift sources
    assign item0 = (dsp_reg >= ONE)   ? t_reg       : '0;
    assign item1 = (dsp_reg >= TWO)   ? mem[sp_reg] : '0;
    assign item2 = (dsp_reg >= THREE) ? mem[sp_dec] : '0;

    assign push  = (delta == 2'b01);
    assign pop1  = (delta == 2'b11);
    assign pop2  = (delta == 2'b10);
    assign over  = push && (dsp_reg == CAP_V);
    assign under = (pop1 && (dsp_reg == '0)) || (pop2 && (dsp_reg < TWO));
    assign suppress = (over || under) && (WRAP == 0);

    always_comb begin
        dflt = item0;
        case (delta)
            2'b11:   dflt = item1;
            2'b10:   dflt = item2;
            default: dflt = item0;
        endcase
    end

    assign val = we ? din : dflt;

    always_comb begin
        t_next   = t_reg;
        sp_next  = sp_reg;
        dsp_next = dsp_reg;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        err_next = err_reg;
        mem_we   = 1'b0;
        if (en) begin
            ovf_next = over;
            unf_next = under;
            if (!suppress) begin
                t_next = val;
                if (push) begin
                    mem_we   = 1'b1;
                    sp_next  = sp_inc;
                    dsp_next = over ? dsp_reg : dsp_reg + ONE;
                end else if (pop1) begin
                    sp_next  = sp_dec;
                    dsp_next = under ? '0 : dsp_reg - ONE;
                end else if (pop2) begin
                    sp_next  = sp_dec2;
                    dsp_next = under ? '0 : dsp_reg - TWO;
                end
            end
        end
        // A fault in the same cycle as clr_err wins
        if (en && suppress) begin
            err_next = 1'b1;
        end else if (clr_err) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_reg   <= '0;
            sp_reg  <= '0;
            dsp_reg <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            t_reg   <= t_next;
            sp_reg  <= sp_next;
            dsp_reg <= dsp_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
            err_reg <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[sp_inc] <= item0;
        end
    end

    assign t     = item0;
    assign n     = item1;
    assign dsp   = dsp_reg;
    assign full  = (dsp_reg == CAP_V);
    assign empty = (dsp_reg == '0);
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;
    assign err   = err_reg;
endmodule

// File: doc/j4_stack.md
Name: j4_stack

Overview:
- Parametrised data/return stack for the j4 core; successor to the fixed j1 stack, which has only a 2-bit delta, a DEPTH-bit wrapping pointer and no error reporting.
- Holds the top of stack T in a register and the rest in an array. Exposes T, N and depth to the ALU and to testbench wiring.
- Adds a -2 delta ("2drop"/"nip-pair"), a selectable wrap or saturate mode, overflow/underflow pulses and a sticky error flag.
- Two instances are planned in the j4 core: data stack and return stack.

Parameters:
- WIDTH, 16, bit width of each stack item.
- DEPTH, 4, log2 of capacity; CAP = 2^DEPTH items including T.
- WRAP, 1, overflow/underflow mode:
  - 1 = j1-compatible circular behaviour.
  - 0 = suppress the offending operation and flag an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  operation enable; 0 = hold all state.
- delta  in  2  signed stack delta: 00 = 0, 01 = +1, 11 = -1, 10 = -2.
- we  in  1  write din into the new T.
- din  in  WIDTH  value for the new T.
- clr_err  in  1  clears the sticky err flag.
- t  out  WIDTH  top of stack item[0]; reads 0 when dsp<1.
- n  out  WIDTH  second item item[1]; reads 0 when dsp<2.
- dsp  out  DEPTH+1  number of valid items, range 0..CAP.
- full  out  1  dsp==CAP, combinational from dsp.
- empty  out  1  dsp==0, combinational from dsp.
- ovf  out  1  one-cycle pulse; the previous cycle's op overflowed.
- unf  out  1  one-cycle pulse; the previous cycle's op underflowed.
- err  out  1  sticky; set by any suppressed op when WRAP=0.

Behaviour:
- Logical model: item[0]=T, item[1]=N, and so on. Any item at index >= dsp reads as 0, both on outputs and as a shift source.
- Reset (rst=1 at an edge, overrides en, clr_err and any operation): dsp=0, ovf=0, unf=0, err=0; t and n read 0. Array contents need not be cleared.
- en=0: no state change; ovf and unf go to 0 at that edge; clr_err still honoured.
- Per enabled edge, with V = we ? din : default:
  - d=0: item[0] <= V; default = item[0].
  - d=+1: item[k+1] <= item[k] for all k; item[0] <= V; default = item[0] (dup).
  - d=-1: item[k] <= item[k+1]; item[0] <= V; default = item[1].
  - d=-2: item[k] <= item[k+2]; item[0] <= V; default = item[2].
  - dsp <= dsp + d.
- Latency: the new t, n and dsp are visible immediately after the edge. Back-to-back ops are allowed every cycle with no bubbles.
- Overflow: d=+1 with dsp==CAP.
  - WRAP=1: op performed, the oldest item is lost, dsp stays CAP, ovf=1 next cycle.
  - WRAP=0: whole op suppressed (we ignored), ovf=1, err=1.
- Underflow: d<0 with dsp < |d|.
  - WRAP=1: op performed, dsp clamps to 0, vacated items read 0, unf=1.
  - WRAP=0: whole op suppressed, unf=1, err=1.
- d=0 never overflows or underflows. we with d=0 on an empty stack writes the internal T, but t stays 0 because dsp stays 0.
- ovf and unf are registered and are 0 on every edge without a fault.
- err priority: rst > set-by-fault > clr_err. A simultaneous fault and clr_err leaves err=1.
- Implementation: dsp is a saturating counter; the array is indexed circularly by a DEPTH-bit pointer. No combinational path from din or delta to any output.

Test Plan:
1. Push/pop ordering, defaults:
   - After rst: push 0x700f, then push 0x0ff0 (d=+1, we) -> dsp=2, t=0x0ff0, n=0x700f.
   - Pop (d=-1, we=0) -> dsp=1, t=0x700f, n=0.
2. Replace and 2drop:
   - Push 1, 2, 3, then d=0 with we, din=0xbeef -> t=0xbeef, n=2, dsp=3.
   - d=-2 with we=0 -> t=1, dsp=1.
   - d=-2 again -> unf=1 next cycle; with WRAP=1, dsp=0 and t=0.
3. Overflow, WRAP=0, DEPTH=2 (CAP=4):
   - Push 1..4 -> full=1.
   - Push 5 -> ovf pulses 1 cycle, err=1, dsp=4, t=4.
   - Pop -> t=3.
   - clr_err -> err=0.
4. Overflow, WRAP=1, DEPTH=2:
   - Push 1..5 -> dsp=4, t=5, ovf pulses.
   - Pop x4 -> t sequence 4, 3, 2, then 0 at dsp=0; item 1 is lost.
5. Reset and stall:
   - Push 3 items, hold en=0 for 3 cycles -> state unchanged.
   - Assert rst concurrently with a push -> dsp=0, t=0, n=0, err=0 after the edge.
6. Simultaneous fault and clr_err (WRAP=0): pop on empty with clr_err=1 -> unf=1, err=1.
